// File: rtl/cache_mem_bridge_pkg.sv
// Shared FSM encoding and memory direction constants for cache_mem_bridge.
package cache_mem_bridge_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        READ    = 2'd1,
        WRITE   = 2'd2,
        RELEASE = 2'd3
    } state_e;

    localparam logic MEM_READ  = 1'b1;
    localparam logic MEM_WRITE = 1'b0;

endpackage

// File: rtl/cache_mem_bridge_write_buffer.sv
// One-entry posted write tracker (used only with BRIDGE_WRITE_BUFFER_EN): acks the
// cache on acceptance and keeps the memory-side write pending until mem_ack drains it.
module bridge_write_buffer (
    input  logic clk,
    input  logic reset,
    input  logic accept_i,
    input  logic write_req_i,
    input  logic mem_done_i,
    output logic ack_o,
    output logic pending_o
);

    logic ack_q;
    logic ack_d;
    logic pending_q;
    logic pending_d;

    always_comb begin
        // Cache-side ack rises with acceptance and falls once the requester lets go.
        ack_d     = ack_q ? write_req_i : accept_i;
        pending_d = pending_q;
        if (accept_i) begin
            pending_d = 1'b1;
        end else if (mem_done_i) begin
            pending_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ack_q     <= 1'b0;
            pending_q <= 1'b0;
        end else begin
            ack_q     <= ack_d;
            pending_q <= pending_d;
        end
    end

    assign ack_o     = ack_q;
    assign pending_o = pending_q;

endmodule

// File: rtl/cache_mem_bridge.sv
// Four-phase cache request to memory master bridge; define BRIDGE_WRITE_BUFFER_EN
// to post writes through a one-entry buffer instead of waiting for mem_ack.
module cache_mem_bridge
    import cache_mem_bridge_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             cache_mem_read_req,
    input  logic [WIDTH-1:0] cache_mem_read_addr,
    output logic [WIDTH-1:0] cache_mem_read_data,
    output logic             cache_mem_read_ack,
    input  logic             cache_mem_write_req,
    input  logic [WIDTH-1:0] cache_mem_write_addr,
    input  logic [WIDTH-1:0] cache_mem_write_data,
    output logic             cache_mem_write_ack,
    output logic             mem_enable,
    output logic             mem_rw,
    output logic [WIDTH-1:0] mem_addr,
    output logic [WIDTH-1:0] mem_data_in,
    input  logic [WIDTH-1:0] mem_data_out,
    input  logic             mem_ack
);

    state_e           state_q;
    logic             mem_enable_q;
    logic             mem_rw_q;
    logic [WIDTH-1:0] mem_addr_q;
    logic [WIDTH-1:0] mem_data_in_q;
    logic [WIDTH-1:0] read_data_q;
    logic             read_ack_q;

`ifdef BRIDGE_WRITE_BUFFER_EN
    logic buf_accept;
    logic buf_done;
    logic buf_ack;
    logic buf_pending;

    assign buf_accept = (state_q == IDLE) && !mem_ack && cache_mem_write_req;
    assign buf_done   = (state_q == WRITE) && mem_enable_q && mem_ack;

    bridge_write_buffer u_write_buffer (
        .clk         (clk),
        .reset       (reset),
        .accept_i    (buf_accept),
        .write_req_i (cache_mem_write_req),
        .mem_done_i  (buf_done),
        .ack_o       (buf_ack),
        .pending_o   (buf_pending)
    );

    assign cache_mem_write_ack = buf_ack;
`else
    logic write_ack_q;

    assign cache_mem_write_ack = write_ack_q;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            // IDLE still refuses requests until mem_ack is low, covering a reset mid-transfer.
            state_q       <= IDLE;
            mem_enable_q  <= 1'b0;
            mem_rw_q      <= 1'b0;
            mem_addr_q    <= '0;
            mem_data_in_q <= '0;
            read_data_q   <= '0;
            read_ack_q    <= 1'b0;
`ifndef BRIDGE_WRITE_BUFFER_EN
            write_ack_q   <= 1'b0;
`endif
        end else begin
            case (state_q)
                IDLE: begin
                    if (!mem_ack) begin
                        if (cache_mem_write_req) begin
                            mem_addr_q    <= cache_mem_write_addr;
                            mem_data_in_q <= cache_mem_write_data;
                            mem_rw_q      <= MEM_WRITE;
                            mem_enable_q  <= 1'b1;
                            state_q       <= WRITE;
                        end else if (cache_mem_read_req) begin
                            mem_addr_q    <= cache_mem_read_addr;
                            mem_rw_q      <= MEM_READ;
                            mem_enable_q  <= 1'b1;
                            state_q       <= READ;
                        end
                    end
                end
                READ: begin
                    // A dropped request wins over a same-cycle mem_ack and is treated as an abort.
                    if (!cache_mem_read_req) begin
                        read_ack_q   <= 1'b0;
                        mem_enable_q <= 1'b0;
                        state_q      <= RELEASE;
                    end else if (mem_ack && !read_ack_q) begin
                        read_data_q <= mem_data_out;
                        read_ack_q  <= 1'b1;
                    end
                end
                WRITE: begin
`ifdef BRIDGE_WRITE_BUFFER_EN
                    if (buf_done) begin
                        mem_enable_q <= 1'b0;
                    end
                    if (!buf_pending && !buf_ack) begin
                        state_q <= RELEASE;
                    end
`else
                    if (!cache_mem_write_req) begin
                        write_ack_q  <= 1'b0;
                        mem_enable_q <= 1'b0;
                        state_q      <= RELEASE;
                    end else if (mem_ack && !write_ack_q) begin
                        write_ack_q <= 1'b1;
                    end
`endif
                end
                RELEASE: begin
                    if (!mem_ack) begin
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign cache_mem_read_data = read_data_q;
    assign cache_mem_read_ack  = read_ack_q;
    assign mem_enable          = mem_enable_q;
    assign mem_rw              = mem_rw_q;
    assign mem_addr            = mem_addr_q;
    assign mem_data_in         = mem_data_in_q;

endmodule

// File: tb/tb_cache_mem_bridge.sv
// Randomized bench for cache_mem_bridge against a 27-cycle latency memory and a
// word-array reference; honours BRIDGE_WRITE_BUFFER_EN for write ack timing.
module tb_cache_mem_bridge;

    localparam int WIDTH   = 32;
    localparam int LATENCY = 27;
    localparam int BOUND   = 300;

    logic             clk = 1'b0;
    logic             reset;
    logic             read_req;
    logic [WIDTH-1:0] read_addr;
    logic [WIDTH-1:0] read_data;
    logic             read_ack;
    logic             write_req;
    logic [WIDTH-1:0] write_addr;
    logic [WIDTH-1:0] write_data;
    logic             write_ack;
    logic             mem_enable;
    logic             mem_rw;
    logic [WIDTH-1:0] mem_addr;
    logic [WIDTH-1:0] mem_data_in;
    logic [WIDTH-1:0] mem_data_out = '0;
    logic             mem_ack = 1'b0;

    int n_checks = 0;
    int n_err    = 0;
    int ack_hold = 0;

    logic [WIDTH-1:0] mem_arr [16];
    logic [WIDTH-1:0] ref_mem [16];
    logic             mem_init = 1'b0;
    int               lat_cnt  = 0;
    int               hold_cnt = 0;
    logic             prev_en  = 1'b0;
    logic             prev_ack = 1'b0;

    always #5 clk = ~clk;

    cache_mem_bridge #(.WIDTH(WIDTH)) dut (
        .clk                  (clk),
        .reset                (reset),
        .cache_mem_read_req   (read_req),
        .cache_mem_read_addr  (read_addr),
        .cache_mem_read_data  (read_data),
        .cache_mem_read_ack   (read_ack),
        .cache_mem_write_req  (write_req),
        .cache_mem_write_addr (write_addr),
        .cache_mem_write_data (write_data),
        .cache_mem_write_ack  (write_ack),
        .mem_enable           (mem_enable),
        .mem_rw               (mem_rw),
        .mem_addr             (mem_addr),
        .mem_data_in          (mem_data_in),
        .mem_data_out         (mem_data_out),
        .mem_ack              (mem_ack)
    );

    // Asynchronous memory: ack LATENCY cycles after enable, hold ack ack_hold extra cycles after enable falls.
    always @(posedge clk) begin
        if (!mem_init) begin
            for (int i = 0; i < 16; i++) mem_arr[i] <= 32'hA500_0000 + i * 32'h101;
            mem_init <= 1'b1;
            mem_ack  <= 1'b0;
            lat_cnt  <= 0;
        end else if (mem_enable && !mem_ack) begin
            if (lat_cnt == LATENCY - 1) begin
                mem_ack  <= 1'b1;
                lat_cnt  <= 0;
                hold_cnt <= ack_hold;
                if (mem_rw) mem_data_out <= mem_arr[mem_addr[5:2]];
                else        mem_arr[mem_addr[5:2]] <= mem_data_in;
            end else begin
                lat_cnt <= lat_cnt + 1;
            end
        end else if (!mem_enable) begin
            lat_cnt <= 0;
            if (mem_ack) begin
                if (hold_cnt == 0) mem_ack <= 1'b0;
                else               hold_cnt <= hold_cnt - 1;
            end
        end
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    always @(negedge clk) begin
        if (!reset) begin
            check("ack_exclusive", {63'b0, read_ack & write_ack}, 64'd0);
            if (mem_enable && !prev_en) check("accept_after_ack_low", {63'b0, prev_ack}, 64'd0);
        end
        prev_en  <= mem_enable;
        prev_ack <= mem_ack;
    end

    task automatic wait_accept(input string tag, output bit ok);
        int n = 0;
        ok = 1'b0;
        while (n < BOUND) begin
            @(negedge clk);
            n++;
            if (mem_enable) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) check({tag, "_accept_timeout"}, 64'd0, 64'd1);
    endtask

    task automatic wait_ack(input string tag, input bit is_read, output int m);
        m = 0;
        while (!(is_read ? read_ack : write_ack) && m < BOUND) begin
            @(negedge clk);
            m++;
        end
        if (m >= BOUND) check({tag, "_ack_timeout"}, 64'd0, 64'd1);
    endtask

    task automatic wait_en_low(input string tag);
        int n = 0;
        while (mem_enable && n < BOUND) begin
            @(negedge clk);
            n++;
        end
        if (n >= BOUND) check({tag, "_release_timeout"}, 64'd0, 64'd1);
    endtask

    task automatic do_read(input logic [WIDTH-1:0] addr);
        bit               ok;
        int               m;
        logic [WIDTH-1:0] exp;
        logic [WIDTH-1:0] got;
        exp       = ref_mem[addr[5:2]];
        got       = '0;
        read_addr = addr;
        read_req  = 1'b1;
        wait_accept("rd", ok);
        if (ok) begin
            check("rd_mem_rw", mem_rw, 1);
            check("rd_mem_addr", mem_addr, addr);
            read_addr = $urandom;
            wait_ack("rd", 1'b1, m);
            check("rd_latency", m, LATENCY + 1);
            check("rd_addr_held", mem_addr, addr);
            got = read_data;
            check("rd_data", got, exp);
        end
        read_req = 1'b0;
        @(negedge clk);
        check("rd_ack_clear", read_ack, 0);
        check("rd_en_clear", mem_enable, 0);
        check("rd_data_hold", read_data, got);
        wait_en_low("rd");
    endtask

    task automatic do_write(input logic [WIDTH-1:0] addr, input logic [WIDTH-1:0] data);
        bit ok;
        int m;
        write_addr = addr;
        write_data = data;
        write_req  = 1'b1;
        wait_accept("wr", ok);
        if (ok) begin
            check("wr_mem_rw", mem_rw, 0);
            check("wr_mem_addr", mem_addr, addr);
            check("wr_mem_data", mem_data_in, data);
            write_addr = $urandom;
            write_data = $urandom;
            wait_ack("wr", 1'b0, m);
`ifdef BRIDGE_WRITE_BUFFER_EN
            check("wr_latency", m, 0);
`else
            check("wr_latency", m, LATENCY + 1);
`endif
            check("wr_addr_held", mem_addr, addr);
            check("wr_data_held", mem_data_in, data);
            ref_mem[addr[5:2]] = data;
        end
        write_req = 1'b0;
        @(negedge clk);
        check("wr_ack_clear", write_ack, 0);
`ifndef BRIDGE_WRITE_BUFFER_EN
        check("wr_en_clear", mem_enable, 0);
`endif
        wait_en_low("wr");
    endtask

    initial begin
        bit               ok;
        bit               saw;
        int               m;
        logic [WIDTH-1:0] wd;
        logic [WIDTH-1:0] a;

        for (int i = 0; i < 16; i++) ref_mem[i] = 32'hA500_0000 + (i << 8) + i;
        reset      = 1'b1;
        read_req   = 1'b0;
        write_req  = 1'b0;
        read_addr  = '0;
        write_addr = '0;
        write_data = '0;
        repeat (3) @(negedge clk);
        check("rst_enable", mem_enable, 0);
        check("rst_rw", mem_rw, 0);
        check("rst_addr", mem_addr, 0);
        check("rst_data_in", mem_data_in, 0);
        check("rst_read_data", read_data, 0);
        check("rst_acks", {read_ack, write_ack}, 0);
        reset = 1'b0;
        @(negedge clk);

        do_read(32'h004);

        ack_hold = 3;
        do_write(32'h010, 32'hDEAD_BEEF);
        do_read(32'h010);
        ack_hold = 0;

        // Simultaneous requests: write first, read served afterwards and sees the new data.
        wd = 32'h0BAD_F00D;
        write_addr = 32'h008;
        write_data = wd;
        read_addr  = 32'h008;
        write_req  = 1'b1;
        read_req   = 1'b1;
        wait_accept("both", ok);
        check("both_write_first", mem_rw, 0);
        wait_ack("both", 1'b0, m);
        ref_mem[2] = wd;
        write_req = 1'b0;
        wait_ack("both_rd", 1'b1, m);
        check("both_read_rw", mem_rw, 1);
        check("both_read_data", read_data, wd);
        read_req = 1'b0;
        @(negedge clk);
        wait_en_low("both");

        // Abort a read ten cycles into the memory latency.
        read_addr = 32'h00C;
        read_req  = 1'b1;
        wait_accept("abort", ok);
        repeat (10) @(negedge clk);
        read_req = 1'b0;
        @(negedge clk);
        check("abort_en_clear", mem_enable, 0);
        saw = 1'b0;
        repeat (40) begin
            @(negedge clk);
            if (read_ack) saw = 1'b1;
        end
        check("abort_no_ack", saw, 0);
        do_read(32'h00C);

        // Reset in the middle of a write.
        write_addr = 32'h018;
        write_data = 32'h1234_5678;
        write_req  = 1'b1;
        wait_accept("rstw", ok);
        repeat (5) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        check("rstw_enable", mem_enable, 0);
        check("rstw_rw", mem_rw, 0);
        check("rstw_addr", mem_addr, 0);
        check("rstw_data_in", mem_data_in, 0);
        check("rstw_read_data", read_data, 0);
        check("rstw_acks", {read_ack, write_ack}, 0);
        write_req = 1'b0;
        reset     = 1'b0;
        do_read(32'h018);

`ifdef BRIDGE_WRITE_BUFFER_EN
        // Posted write followed at once by a read that must stall behind it.
        write_addr = 32'h020;
        write_data = 32'hCAFE_0020;
        write_req  = 1'b1;
        wait_accept("buf", ok);
        wait_ack("buf", 1'b0, m);
        check("buf_wr_ack_latency", m, 0);
        ref_mem[8] = 32'hCAFE_0020;
        write_req = 1'b0;
        read_addr = 32'h024;
        read_req  = 1'b1;
        wait_ack("buf_rd", 1'b1, m);
        check("buf_rd_stalled", {63'b0, m > 2 * LATENCY}, 64'd1);
        check("buf_rd_data", read_data, ref_mem[9]);
        read_req = 1'b0;
        @(negedge clk);
        wait_en_low("buf");
        do_read(32'h020);
`endif

        for (int t = 0; t < 40; t++) begin
            a        = 32'($urandom_range(0, 15)) << 2;
            ack_hold = $urandom_range(0, 3);
            if ($urandom_range(0, 1) == 1) do_write(a, $urandom);
            else                           do_read(a);
        end

        repeat (5) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "global timeout");
    end

endmodule

// File: doc/cache_mem_bridge.md
CACHE_MEM_BRIDGE -- requirements
Module: cache_mem_bridge

Interface
REQ-001 SHALL have parameter WIDTH, default 32, data and address width in bits.
REQ-002 SHALL have clk  input  1  single clock; all state changes on its rising edge.
REQ-003 SHALL have reset  input  1  synchronous, active-high reset.
REQ-004 SHALL have cache_mem_read_req  input  1  cache read request, level, four-phase.
REQ-005 SHALL have cache_mem_read_addr  input  WIDTH  read address.
REQ-006 SHALL have cache_mem_read_data  output  WIDTH  read data, valid while cache_mem_read_ack=1.
REQ-007 SHALL have cache_mem_read_ack  output  1  read completion.
REQ-008 SHALL have cache_mem_write_req  input  1  cache write request, level, four-phase.
REQ-009 SHALL have cache_mem_write_addr  input  WIDTH  write address.
REQ-010 SHALL have cache_mem_write_data  input  WIDTH  write data.
REQ-011 SHALL have cache_mem_write_ack  output  1  write completion.
REQ-012 SHALL have mem_enable  output  1  memory master_enable.
REQ-013 SHALL have mem_rw  output  1  memory read_write: 1 read, 0 write.
REQ-014 SHALL have mem_addr  output  WIDTH  memory address.
REQ-015 SHALL have mem_data_in  output  WIDTH  data to memory.
REQ-016 SHALL have mem_data_out  input  WIDTH  data from memory.
REQ-017 SHALL have mem_ack  input  1  memory completion; memory drops it after mem_enable falls.

Function
REQ-018 SHALL implement FSM states IDLE, READ, WRITE, RELEASE; all outputs registered.
REQ-019 IDLE: write_req=1 SHALL take priority over read_req; on acceptance latch addr/data into mem_addr/mem_data_in, set mem_rw, mem_enable=1 next cycle, go WRITE or READ.
REQ-020 Cache-side addr/data changes after acceptance SHALL be ignored until return to IDLE.
REQ-021 READ: first cycle mem_ack=1 sampled SHALL capture mem_data_out into cache_mem_read_data and set cache_mem_read_ack=1 next cycle; mem_enable stays 1.
REQ-022 WRITE: first cycle mem_ack=1 sampled SHALL set cache_mem_write_ack=1 next cycle.
REQ-023 When the requester drops req while its ack=1, SHALL clear ack and mem_enable next cycle and go RELEASE.
REQ-024 Req dropped before mem_ack (abort): SHALL clear mem_enable, generate no ack, go RELEASE.
REQ-025 RELEASE SHALL return to IDLE in the cycle mem_ack is sampled 0; no new request accepted before.
REQ-026 cache_mem_read_data SHALL hold its last captured value outside READ.
REQ-027 Read and write ack SHALL never be 1 simultaneously.

Reset
REQ-028 reset=1 SHALL force IDLE and all outputs to 0 (including data/address outputs) on the next edge, from any state, mid-transaction included.
REQ-029 After reset the bridge SHALL wait in RELEASE semantics until mem_ack=0 before accepting requests.

Configuration
REQ-030 Macro BRIDGE_WRITE_BUFFER_EN SHALL enable a one-entry posted write buffer.
REQ-031 With it: accepted write SHALL be acked the cycle after acceptance and released on req drop; memory write proceeds in background; a second write or any read SHALL stall until buffer drains; a read stall SHALL end only after buffer memory write receives mem_ack and RELEASE completes.
REQ-032 Without it: writes SHALL ack only after mem_ack per REQ-022.

Structure
REQ-033 Package cache_mem_bridge_pkg SHALL hold FSM state encoding and constants MEM_READ=1, MEM_WRITE=0.
REQ-034 Buffer logic SHALL be sub-module bridge_write_buffer, instantiated only under BRIDGE_WRITE_BUFFER_EN.

Verification (memory_async, LATENCY=27, DEPTH=4)
REQ-035 Read 0x004 -> mem_enable=1, mem_rw=1, mem_addr=0x004; read_ack after 27-cycle latency plus 1 cycle, data = memory word 1.
REQ-036 Write 0x010 data 0xDEADBEEF, then read 0x010 -> read data 0xDEADBEEF.
REQ-037 read_req and write_req rise same cycle -> write served first (mem_rw=0), read served after RELEASE.
REQ-038 read_req dropped at cycle 10 of 27 -> no read_ack, mem_enable=0 next cycle, next request accepted only after mem_ack=0.
REQ-039 reset in WRITE state -> all outputs 0 next cycle, state IDLE.
REQ-040 With BRIDGE_WRITE_BUFFER_EN, write 0x020 -> write_ack 1 cycle after acceptance; immediate read 0x024 -> stalls until buffered write completes.
